dmem_dual_issue_ctrl: RTL
=========================

# dmem_dual_issue_ctrl

Issue controller for the dual-port data memory in the superscalar execute/memory stage. It accepts one in-order load/store pair per cycle from lanes 1 (older) and 2 (younger), drives both memory ports and returns registered load data. When same-cycle issue would break program order, it splits the pair across two cycles. The memory forwards a port's write data to the other port's read at a matching index; that suits lane-1-store/lane-2-load, but a lane-1-load/lane-2-store to the same index would return the younger store's data.

## Interface
- IDX_BITS, 8, memory index width; address compare and conflict detection use addr[IDX_BITS-1:0]
- CNT_W, 16, width of the split-event counter
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid_1 / req_valid_2  in  1  lane request valid
- req_we_1 / req_we_2  in  1  1 = store, 0 = load
- req_addr_1 / req_addr_2  in  32  byte-agnostic word address
- req_wdata_1 / req_wdata_2  in  32  store data
- req_ready  out  1  pair accepted this cycle (one ready for both lanes)
- mem_read_1 / mem_read_2, mem_write_1 / mem_write_2  out  1  memory port enables
- mem_addr_1 / mem_addr_2, mem_wdata_1 / mem_wdata_2  out  32  memory port address/data
- mem_rdata_1 / mem_rdata_2  in  32  combinational memory read data
- rsp_valid_1 / rsp_valid_2  out  1  load data valid, one-cycle pulse
- rsp_rdata_1 / rsp_rdata_2  out  32  registered load data
- split_cnt  out  CNT_W  saturating count of split pairs

## Operation
- States: IDLE (accepting), HOLD (lane-2 request parked in the hold register).
- IDLE: req_ready=1. Ports are driven combinationally from the lane inputs: port n is enabled only if req_valid_n is set, mem_write_n=req_we_n and mem_read_n=!req_we_n.
- Conflict condition: both valid, lane 1 is a load, lane 2 is a store, and index_1==index_2. On conflict:
  - issue lane 1 only;
  - capture the lane-2 request in the hold register;
  - go to HOLD and increment split_cnt, saturating at all-ones.
- Non-conflicting pairs issue together. Store-store to the same index needs no split, because the memory's write order makes lane 2 win. Lane-1-store/lane-2-load relies on the memory's forwarding.
- Only one lane valid: that lane issues on its own port.
- HOLD: req_ready=0. Port 1 is disabled and port 2 is driven from the hold register. HOLD returns to IDLE unconditionally the next cycle.
- Load response: at the posedge that closes the issue cycle, rsp_rdata_n <= mem_rdata_n and rsp_valid_n <= 1. Otherwise rsp_valid_n <= 0 and rsp_rdata_n holds.
- Requests presented while req_ready=0 are ignored, and requesters must hold them. Changing a held request while req_ready=0 is illegal and undefined.

## Timing
- Reset (async assert, sync-safe release): state=IDLE, hold register=0, split_cnt=0, rsp_valid_*=0, rsp_rdata_*=0.
- While rst_n=0: req_ready=0 and all mem enables=0. mem_addr_* and mem_wdata_*=0.
- Load latency is 1 cycle after issue: rsp_valid_n rises in cycle T+1 for issue cycle T.
- Stores commit at the posedge ending the issue cycle.
- Split pair, accepted in cycle T: lane 1 issues in T, lane 2 issues in T+1, req_ready=0 in T+1. The lane-2 load response, if any, is in T+2 on rsp_*_2.
- Reset during HOLD: the parked request is discarded. No memory access or response is generated.
- Zero-bubble throughput for non-conflicting pairs: one pair per cycle.

## Structure
- Package dmem_ctrl_pkg holds:
  - state enum {IDLE, HOLD};
  - IDX_BITS default;
  - a request struct {valid, we, addr[31:0], wdata[31:0]} used for the lane inputs and the hold register.
- No sub-module is required. Conflict detection stays inline as one comparator plus gating.

## Test plan
- Reset, then lane 1 loads addr 5 alone: mem_read_1=1 in T, rsp_valid_1=1 with rsp_rdata_1=5 in T+1 (mem init mem[i]=i); req_ready stays 1.
- Lane 1 loads 10 and lane 2 stores 99 to 10 in the same cycle: split, with req_ready=0 in T+1 and split_cnt=1. rsp_rdata_1=10 in T+1; a later load of 10 returns 99.
- Lane 1 stores 77 to 20 and lane 2 loads 20: no split, and rsp_rdata_2=77 in T+1.
- Both lanes store to 30 (11 then 22): no split, and a later load of 30 returns 22.
- Conflicting pair, then assert rst_n=0 during HOLD: the lane-2 store to addr 40 never commits, a later load of 40 returns 40, and all outputs are at reset values.
- Force 2^CNT_W+3 conflicts: split_cnt saturates at all-ones and does not wrap.

Source files
------------

// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the dual-issue data memory controller.
// Holds the FSM state encoding and the lane request bundle.
package dmem_ctrl_pkg;

  localparam int IDX_BITS_DEF = 8;
  localparam int CNT_W_DEF    = 16;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_e;

  typedef struct packed {
    logic        valid;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  function automatic logic is_load(input req_t r);
    return r.valid & ~r.we;
  endfunction

  function automatic logic is_store(input req_t r);
    return r.valid & r.we;
  endfunction

endpackage

// File: rtl/dmem_dual_issue_ctrl.sv
// Dual-port data memory issue control for the two memory lanes.
// Splits load-then-store pairs that hit the same index into two cycles.
module dmem_dual_issue_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int IDX_BITS = IDX_BITS_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid_1,
  input  logic             req_valid_2,
  input  logic             req_we_1,
  input  logic             req_we_2,
  input  logic [31:0]      req_addr_1,
  input  logic [31:0]      req_addr_2,
  input  logic [31:0]      req_wdata_1,
  input  logic [31:0]      req_wdata_2,
  output logic             req_ready,
  output logic             mem_read_1,
  output logic             mem_read_2,
  output logic             mem_write_1,
  output logic             mem_write_2,
  output logic [31:0]      mem_addr_1,
  output logic [31:0]      mem_addr_2,
  output logic [31:0]      mem_wdata_1,
  output logic [31:0]      mem_wdata_2,
  input  logic [31:0]      mem_rdata_1,
  input  logic [31:0]      mem_rdata_2,
  output logic             rsp_valid_1,
  output logic             rsp_valid_2,
  output logic [31:0]      rsp_rdata_1,
  output logic [31:0]      rsp_rdata_2,
  output logic [CNT_W-1:0] split_cnt
);

  state_e state;
  state_e state_d;
  req_t   hold;
  req_t   hold_d;
  req_t   lane_1;
  req_t   lane_2;
  req_t   port_1;
  req_t   port_2;
  logic   same_idx;
  logic   conflict;
  logic   split_inc;

  assign lane_1 = '{req_valid_1, req_we_1, req_addr_1, req_wdata_1};
  assign lane_2 = '{req_valid_2, req_we_2, req_addr_2, req_wdata_2};

  // Memory forwards store data across ports, so only an older load
  // beside a younger store to the same index can see the wrong value.
  assign same_idx =
    lane_1.addr[IDX_BITS-1:0] == lane_2.addr[IDX_BITS-1:0];
  assign conflict =
    is_load(lane_1) & is_store(lane_2) & same_idx;

  always_comb begin
    state_d   = state;
    hold_d    = hold;
    split_inc = 1'b0;
    req_ready = 1'b0;
    port_1    = '0;
    port_2    = '0;
    if (rst_n) begin
      unique case (state)
        IDLE: begin
          req_ready = 1'b1;
          port_1    = lane_1;
          port_2    = lane_2;
          if (conflict) begin
            port_2    = '0;
            hold_d    = lane_2;
            state_d   = HOLD;
            split_inc = 1'b1;
          end
        end
        HOLD: begin
          port_2  = hold;
          hold_d  = '0;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign mem_read_1  = is_load(port_1);
  assign mem_write_1 = is_store(port_1);
  assign mem_addr_1  = port_1.addr;
  assign mem_wdata_1 = port_1.wdata;

  assign mem_read_2  = is_load(port_2);
  assign mem_write_2 = is_store(port_2);
  assign mem_addr_2  = port_2.addr;
  assign mem_wdata_2 = port_2.wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      hold  <= '0;
    end else begin
      state <= state_d;
      hold  <= hold_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      split_cnt <= '0;
    end else if (split_inc && (split_cnt != '1)) begin
      split_cnt <= split_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_1 <= 1'b0;
      rsp_valid_2 <= 1'b0;
      rsp_rdata_1 <= '0;
      rsp_rdata_2 <= '0;
    end else begin
      rsp_valid_1 <= mem_read_1;
      rsp_valid_2 <= mem_read_2;
      if (mem_read_1) rsp_rdata_1 <= mem_rdata_1;
      if (mem_read_2) rsp_rdata_2 <= mem_rdata_2;
    end
  end

endmodule
